muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative RV32M multiply/divide sequencer beside the execute stage ALU.
//  It accepts one M-extension op from execute and runs a 32-step shift-add multiply or restoring divide.
//  It stalls the pipeline while it runs, then presents the 32-bit result for one cycle.
//  Execute muxes that result onto its result path in place of the ALU output.
// PARAMETERS
//  XLEN    32  operand/result width; only 32 is supported
//  CNT_W   5   iteration counter width; must satisfy 2**CNT_W == XLEN
// PORTS
//  clk        in   1     clock; all state changes on rising edge
//  rst        in   1     asynchronous, active-low reset
//  start      in   1     request: launch op; sampled only in IDLE
//  op         in   3     funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  rs1_value  in   32    operand a (dividend / multiplicand), forwarded value
//  rs2_value  in   32    operand b (divisor / multiplier), forwarded value
//  flush      in   1     abort current op (branch taken / pipeline flush)
//  stall      out  1     hold IF/ID/EX pipeline registers
//  busy       out  1     state != IDLE
//  done       out  1     one-cycle pulse; result valid this cycle
//  result     out  32    op result; held until next op completes
// BEHAVIOUR
//  Reset (rst=0, asynchronous)
//   - state=IDLE; counter, accumulators and result=0; done=0, busy=0.
//   - Reset mid-op discards the op; no done is produced.
//  FSM: IDLE -> CALC -> DONE -> IDLE
//   - IDLE: start=1 and flush=0 at edge E0 latches op, operand magnitudes and sign flags, then -> CALC with cnt=0.
//     MULHSU treats only rs1 as signed. Unsigned ops never negate.
//   - CALC: one step per cycle, cnt++. Leave after step cnt=31 (32 steps, edges E1..E32) -> DONE.
//     MUL*: 64-bit product register, add-and-shift on multiplier LSB.
//     DIV*/REM*: restoring divide; 33-bit partial remainder, quotient shifted in.
//   - DONE: apply sign fix and drive result. done=1 for exactly one cycle (between E32 and E33), then -> IDLE.
//  Timing and handshake
//   - Latency: start sampled at E0 -> done high in the cycle after E32.
//   - stall = (start & IDLE & ~flush) | (state==CALC). stall is 0 in DONE so execute captures result that cycle.
//   - start is ignored while busy; execute must not re-issue until done.
//   - A new start may be accepted on the edge leaving DONE (back-to-back ops).
//  Result selection
//   - MUL: low 32 bits. MULH/MULHSU/MULHU: high 32 bits of the correctly signed 64-bit product.
//   - DIV/DIVU: quotient. REM/REMU: remainder.
//   - Signs: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
//  Corner cases (RISC-V mandated)
//   - Divide by zero: quotient=32'hFFFF_FFFF, remainder=rs1.
//   - Signed overflow 32'h8000_0000 / -1: quotient=32'h8000_0000, remainder=0.
//   - These take the full 32-cycle path unless early-out is compiled in.
//  Flush: in CALC or DONE -> IDLE next edge, done suppressed, result unchanged. Flush with start in IDLE: op not accepted.
//  Simultaneous reset and flush: reset dominates.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN
//   - Defined: divide-by-zero, signed overflow, and MUL* with either operand 0 go IDLE -> DONE directly.
//     done is then high in the cycle after E0 (latency 1), and stall drops after E0.
//   - Undefined: every op takes exactly 32 CALC cycles; latency is fixed and data-independent.
// STRUCTURE
//  Shared header muldiv_defs.vh, guarded by `ifndef like the other cpu headers:
//   - op encodings (MD_MUL..MD_REMU), FSM state localparams (S_IDLE/S_CALC/S_DONE), XLEN.
//  Sub-module muldiv_sign_fix (combinational): magnitude result + sign flags + op -> final result, including corner-case overrides.
//  The FSM, counter and iteration registers stay in muldiv_seq.
// TESTING
//  1. MUL: rs1=7, rs2=-3 -> done 33 cycles after start; result=32'hFFFF_FFEB; stall high for cycles 0..32.
//  2. MULH: rs1=32'h8000_0000, rs2=32'h8000_0000 -> result=32'h4000_0000. MULHU on the same operands -> 32'h4000_0000.
//     MULHSU (rs1=-1, rs2=2) -> 32'hFFFF_FFFF.
//  3. DIV: rs1=-7, rs2=2 -> result=-3 (32'hFFFF_FFFD). REM on the same operands -> -1. REMU: rs1=7, rs2=2 -> 1.
//  4. DIVU by 0 (rs1=5, rs2=0) -> 32'hFFFF_FFFF. REM by 0 -> 5. DIV 32'h8000_0000 / -1 -> 32'h8000_0000.
//     With MULDIV_EARLY_OUT_EN the same cases give done 1 cycle after start.
//  5. Start DIV, assert flush at cycle 10 -> busy=0 next cycle, no done, result keeps its prior value.
//     An immediate restart completes normally.
//  6. Drop rst at cycle 5 of a MUL -> outputs 0 immediately (async). Back-to-back MUL then DIVU (start on the DONE cycle):
//     both results correct, done pulses 33 cycles apart.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: widths, funct3 op codes, FSM states.
package muldiv_seq_pkg;

    localparam int MD_XLEN  = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_seq_sign_fix.sv
// Turns the unsigned magnitude product/quotient/remainder into the final RV32M result,
// applying operand signs and the divide-by-zero / signed-overflow overrides.
module muldiv_seq_sign_fix
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  op_e             op,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic            div_zero,
    input  logic            ovf,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] result
);

    logic                neg;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;

    // hi/lo hold the 64-bit product for MUL*, or remainder/quotient for DIV*/REM*.
    always_comb begin
        neg    = sign_a ^ sign_b;
        prod   = neg ? -{hi, lo} : {hi, lo};
        quo    = neg ? -lo : lo;
        rem    = sign_a ? -hi : hi;
        result = '0;
        case (op)
            MD_MUL:                        result = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  result = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU: begin
                if (div_zero)
                    result = '1;
                else if (ovf)
                    result = {1'b1, {(XLEN-1){1'b0}}};
                else
                    result = quo;
            end
            MD_REM, MD_REMU:               result = ovf ? '0 : rem;
            default:                       result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or restoring divide.
// Optional build macro MULDIV_EARLY_OUT_EN sends trivial ops (div by zero, overflow, MUL by 0) straight to DONE.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = MD_XLEN,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e            state, state_next;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q;
    logic              sign_a, sign_b, div_zero, ovf;
    logic [XLEN-1:0]   mag_a, mag_b, hi, lo, result_q, fix_result;

    logic              accept, early, is_mul, signed_a, signed_b;
    logic              in_sign_a, in_sign_b, in_div_zero, in_ovf;
    logic [XLEN-1:0]   in_mag_a, in_mag_b;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;

    // Operand decode at launch; MULHSU treats only rs1 as signed, unsigned ops never negate.
    always_comb begin
        is_mul      = ~op[2];
        signed_a    = (op != MD_MULHU) && (op != MD_DIVU) && (op != MD_REMU);
        signed_b    = signed_a && (op != MD_MULHSU);
        in_sign_a   = signed_a & rs1_value[XLEN-1];
        in_sign_b   = signed_b & rs2_value[XLEN-1];
        in_mag_a    = in_sign_a ? -rs1_value : rs1_value;
        in_mag_b    = in_sign_b ? -rs2_value : rs2_value;
        in_div_zero = ~is_mul && (rs2_value == '0);
        in_ovf      = ~is_mul && signed_a && (rs1_value == {1'b1, {(XLEN-1){1'b0}}})
                      && (rs2_value == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early       = in_div_zero | in_ovf
                      | (is_mul && ((rs1_value == '0) || (rs2_value == '0)));
`else
        early       = 1'b0;
`endif
    end

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b};
    end

    // Next state and handshake outputs; a new op may also launch from DONE.
    always_comb begin
        accept     = start & ~flush & ((state == S_IDLE) || (state == S_DONE));
        state_next = state;
        case (state)
            S_IDLE: if (accept) state_next = early ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush)
                    state_next = S_IDLE;
                else if (cnt == CNT_W'(XLEN-1))
                    state_next = S_DONE;
            end
            S_DONE: begin
                if (accept)
                    state_next = early ? S_DONE : S_CALC;
                else
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        stall  = (start & ~flush & (state == S_IDLE)) | (state == S_CALC);
        busy   = (state != S_IDLE);
        done   = (state == S_DONE) & ~flush;
        result = done ? fix_result : result_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            op_q     <= MD_MUL;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            hi       <= '0;
            lo       <= '0;
            result_q <= '0;
        end else begin
            if (done)
                result_q <= fix_result;
            if (accept) begin
                op_q     <= op_e'(op);
                sign_a   <= in_sign_a;
                sign_b   <= in_sign_b;
                div_zero <= in_div_zero;
                ovf      <= in_ovf;
                mag_a    <= in_mag_a;
                mag_b    <= in_mag_b;
                cnt      <= '0;
                hi       <= '0;
                lo       <= is_mul ? in_mag_b : in_mag_a;
                // Skipped ops must leave hi/lo as the full iteration would have.
                if (early) begin
                    hi <= in_div_zero ? in_mag_a : '0;
                    lo <= '0;
                end
            end else if (state == S_CALC) begin
                cnt <= cnt + CNT_W'(1);
                if (~op_q[2]) begin
                    hi <= mul_sum[XLEN:1];
                    lo <= {mul_sum[0], lo[XLEN-1:1]};
                end else if (!div_diff[XLEN]) begin
                    hi <= div_diff[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b1};
                end else begin
                    hi <= div_shift[XLEN-1:0];
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
            end
        end
    end

    muldiv_seq_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op       (op_q),
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .div_zero (div_zero),
        .ovf      (ovf),
        .hi       (hi),
        .lo       (lo),
        .result   (fix_result)
    );

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq; latency expectations follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs1_value = '0;
    logic [31:0] rs2_value = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    muldiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1_value (rs1_value),
        .rs2_value (rs2_value),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, actual, expected);
        end
    endtask

    // Caller is at a negedge; drives a request across exactly one rising edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
        op        = o;
        rs1_value = a;
        rs2_value = b;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(output int n, output bit stall_err);
        n = 0;
        stall_err = 1'b0;
        while (n < TIMEOUT) begin
            @(negedge clk);
            n++;
            if (done)
                break;
            if (stall !== 1'b1)
                stall_err = 1'b1;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected, input bit trivial);
        int n;
        bit stall_err;
        int lat;
        lat = (EARLY_OUT && trivial) ? 1 : 33;
        @(negedge clk);
        op = o; rs1_value = a; rs2_value = b; start = 1'b1;
        #1 checkOutput({tag, " stall@start"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(n, stall_err);
        checkOutput({tag, " latency"}, 32'(n), 32'(lat));
        checkOutput({tag, " result"}, result, expected);
        checkOutput({tag, " stall busy"}, 32'(stall_err), 32'd0);
        checkOutput({tag, " stall@done"}, 32'(stall), 32'd0);
    endtask

    initial begin
        int n;
        bit stall_err;
        bit seen_done;

        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset result", result, 32'h0);
        rst = 1'b1;

        runOp("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        @(negedge clk);
        checkOutput("held result", result, 32'hFFFF_FFEB);
        checkOutput("idle busy", 32'(busy), 32'd0);

        runOp("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        runOp("MULHU", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        runOp("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
        runOp("MULHU -1*2", 3'b011, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0);
        runOp("MUL 0*5", 3'b000, 32'd0, 32'd5, 32'h0, 1'b1);

        runOp("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        runOp("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        runOp("REMU 7/2", 3'b111, 32'd7, 32'd2, 32'h1, 1'b0);
        runOp("DIVU max/2", 3'b101, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 1'b0);

        runOp("DIVU 5/0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        runOp("REM 5/0", 3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
        runOp("DIV -7/0", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1'b1);
        runOp("REM -7/0", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1);
        runOp("REM min/-1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        runOp("DIV min/-1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Flush partway through a divide.
        @(negedge clk);
        applyStimulus(3'b100, 32'd100, 32'd7);
        seen_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        flush = 1'b1;
        #1 if (done) seen_done = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("flush busy", 32'(busy), 32'd0);
        checkOutput("flush no done", 32'(seen_done | done), 32'd0);
        checkOutput("flush result kept", result, 32'h8000_0000);
        runOp("DIV after flush", 3'b100, 32'd100, 32'd7, 32'd14, 1'b0);

        // Start together with flush in IDLE is refused.
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op = 3'b000; rs1_value = 32'd3; rs2_value = 32'd3;
        #1 checkOutput("flush+start stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        checkOutput("flush+start busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-multiply.
        @(negedge clk);
        applyStimulus(3'b000, 32'd9, 32'd9);
        repeat (5) @(negedge clk);
        checkOutput("busy before reset", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("async reset busy", 32'(busy), 32'd0);
        checkOutput("async reset stall", 32'(stall), 32'd0);
        checkOutput("async reset result", result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post reset done", 32'(done), 32'd0);
        checkOutput("post reset result", result, 32'h0);

        // Back-to-back: second op launched on the DONE cycle of the first.
        @(negedge clk);
        applyStimulus(3'b000, 32'd6, 32'd7);
        waitDone(n, stall_err);
        checkOutput("b2b MUL latency", 32'(n), 32'd33);
        checkOutput("b2b MUL result", result, 32'd42);
        applyStimulus(3'b101, 32'd100, 32'd7);
        waitDone(n, stall_err);
        checkOutput("b2b DIVU spacing", 32'(n), 32'd33);
        checkOutput("b2b DIVU result", result, 32'd14);
        checkOutput("b2b DIVU stall", 32'(stall_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
